half_adder: RTL and testbench
=============================

Name: half_adder

Overview:
- Bitwise half adder with a zero-latency combinational path and an optional registered output stage.
- Also provides a saturating counter of generated carries.
- Used as a leaf arithmetic cell and as a building block for full adders and ripple/compressor trees.
- With WIDTH=1 the combinational ports form the classic 1-bit half adder (a, b -> sum, carry).

Parameters:
- WIDTH, 1, number of independent 1-bit half-adder lanes; lane i uses a[i], b[i].
- CNT_W, 16, width of carry_count.

Ports:
- clk  input  1  clock, rising-edge active; used by the registered stage and counter only.
- rst_n  input  1  asynchronous active-low reset.
- a  input  WIDTH  operand A, one bit per lane.
- b  input  WIDTH  operand B, one bit per lane.
- sum  output  WIDTH  combinational sum, a XOR b per lane.
- carry  output  WIDTH  combinational carry, a AND b per lane.
- in_valid  input  1  qualifies a/b for the registered stage and the counter.
- sum_q  output  WIDTH  registered sum.
- carry_q  output  WIDTH  registered carry.
- out_valid  output  1  registered copy of in_valid.
- clear_count  input  1  synchronous clear of carry_count.
- carry_count  output  CNT_W  saturating count of carry bits generated on accepted cycles.

Behaviour:

Combinational path:
- sum[i] = a[i] ^ b[i]; carry[i] = a[i] & b[i].
- Zero latency. Independent of clk, rst_n, in_valid and clear_count.
- Must be correct with no clock toggling and with reset asserted.

Truth table, per lane:
- 00 -> sum 0, carry 0
- 01 -> sum 1, carry 0
- 10 -> sum 1, carry 0
- 11 -> sum 0, carry 1
- sum and carry are never both 1.

Reset:
- While rst_n=0, sum_q, carry_q, out_valid and carry_count are 0, asynchronously and immediately.
- Release is sampled at the next rising clk edge.

Registered stage, per rising clk edge:
- out_valid <= in_valid.
- If in_valid=1: sum_q <= sum, carry_q <= carry.
- If in_valid=0: sum_q and carry_q hold their previous values.
- Latency is 1 cycle from accepted inputs to sum_q/carry_q/out_valid.

Counter, per rising clk edge:
- If clear_count=1: carry_count <= 0. Clear wins over a simultaneous increment.
- Else if in_valid=1: carry_count <= carry_count + popcount(carry).
- The addition saturates at 2^CNT_W-1; no wrap-around.
- A partial increment that would overflow clamps to max.

Reset mid-operation:
- Asserting rst_n=0 at any time forces the registered outputs to 0 without waiting for clk.
- The combinational outputs continue to track a and b.

Inputs:
- No X-propagation handling is required beyond standard operator semantics.

Test Plan:
1. WIDTH=1, no clock, rst_n=0. Apply a/b = 00, 01, 10, 11 with 5 ns each. Required sum/carry = 0/0, 1/0, 1/0, 0/1, settled within each 5 ns step.
2. Assert rst_n=0 mid-run with in_valid=1 and a=b=1 -> sum_q, carry_q, out_valid and carry_count read 0 immediately, before any clk edge. After release, the next edge gives carry_q=1 and out_valid=1.
3. in_valid pulses: cycle 0 a=1, b=0, in_valid=1; cycle 1 a=1, b=1, in_valid=0. After the edges, sum_q=1, carry_q=0 held, out_valid=0, carry_count unchanged.
4. WIDTH=4: a=4'b1011, b=4'b0111, in_valid=1 for 3 cycles. Required sum=4'b1100, carry=4'b0011, carry_count=6 after 3 edges.
5. CNT_W=3, WIDTH=1: a=b=1, in_valid=1 for 10 cycles. carry_count rises to 7 and stays 7. Then clear_count=1 together with in_valid=1 -> carry_count=0 next edge.
6. Random a/b/in_valid for 1000 cycles against a reference model -> combinational outputs match every step; registered outputs match with 1-cycle delay; counter matches including saturation.

Source files
------------

// File: rtl/half_adder.sv
// ---------------------------------------------------------------------------
// half_adder
//   WIDTH independent 1-bit half-adder lanes. Each lane has a zero-latency
//   combinational sum/carry, plus an optional one-cycle registered copy that
//   is qualified by in_valid. A saturating counter accumulates how many carry
//   bits were produced on accepted (in_valid) cycles.
//
// Parameters
//   WIDTH        number of independent lanes (lane i uses a[i], b[i])
//   CNT_W        width of carry_count
//
// Ports
//   clk          rising-edge clock (registered stage and counter only)
//   rst_n        asynchronous active-low reset
//   a, b         operands, one bit per lane
//   sum, carry   combinational a^b and a&b per lane
//   in_valid     qualifies a/b for the registered stage and the counter
//   sum_q        registered sum, holds when in_valid=0
//   carry_q      registered carry, holds when in_valid=0
//   out_valid    registered copy of in_valid
//   clear_count  synchronous clear of carry_count, wins over an increment
//   carry_count  saturating count of carry bits on accepted cycles
// ---------------------------------------------------------------------------
module half_adder #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry,
   input  logic             in_valid,
   output logic [WIDTH-1:0] sum_q,
   output logic [WIDTH-1:0] carry_q,
   output logic             out_valid,
   input  logic             clear_count,
   output logic [CNT_W-1:0] carry_count
);

   // Enough bits to hold a popcount of 0..WIDTH.
   localparam int PC_W  = (WIDTH > 1) ? $clog2(WIDTH + 1) : 1;
   // Headroom so that count + popcount never wraps before the clamp.
   localparam int SUM_W = CNT_W + PC_W;

   logic [PC_W-1:0]  carry_pop;
   logic [SUM_W-1:0] count_ext;
   logic             count_ovf;
   logic [CNT_W-1:0] count_next;

   assign sum   = a ^ b;
   assign carry = a & b;

   always_comb begin
      carry_pop = '0;
      for (int i = 0; i < WIDTH; i++) begin
         carry_pop = carry_pop + PC_W'(carry[i]);
      end
   end

   assign count_ext = SUM_W'(carry_count) + SUM_W'(carry_pop);
   // Any bit above the counter width means the true sum exceeds the max.
   assign count_ovf = |count_ext[SUM_W-1:CNT_W];

   always_comb begin
      count_next = carry_count;
      if (clear_count) begin
         count_next = '0;
      end else if (in_valid) begin
         count_next = count_ovf ? {CNT_W{1'b1}} : count_ext[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q       <= '0;
         carry_q     <= '0;
         out_valid   <= 1'b0;
         carry_count <= '0;
      end else begin
         out_valid   <= in_valid;
         carry_count <= count_next;
         if (in_valid) begin
            sum_q   <= sum;
            carry_q <= carry;
         end
      end
   end

endmodule

// File: tb/tb_half_adder.sv
module tb_half_adder;

   logic clk;
   logic clk_en;
   logic rst_n;

   // wide instance: 4 lanes, 5-bit counter (saturates during random run)
   logic [3:0] a4, b4, sum4, carry4, sq4, cq4;
   logic       iv4, clr4, ov4;
   logic [4:0] cnt4;

   // narrow instance: 1 lane, 3-bit counter
   logic       a1, b1, sum1, carry1, sq1, cq1;
   logic       iv1, clr1, ov1;
   logic [2:0] cnt1;

   int n_cmp;
   int n_err;

   half_adder #(.WIDTH(4), .CNT_W(5)) u_w4 (
      .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .sum(sum4), .carry(carry4),
      .in_valid(iv4), .sum_q(sq4), .carry_q(cq4), .out_valid(ov4),
      .clear_count(clr4), .carry_count(cnt4)
   );

   half_adder #(.WIDTH(1), .CNT_W(3)) u_w1 (
      .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sum(sum1), .carry(carry1),
      .in_valid(iv1), .sum_q(sq1), .carry_q(cq1), .out_valid(ov1),
      .clear_count(clr1), .carry_count(cnt1)
   );

   initial clk = 1'b0;
   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic a;
      logic b;
      logic s;
      logic c;
   } vec_t;

   vec_t tt[4];

   // reference model state
   int m_sq4, m_cq4, m_ov4, m_cnt4;
   int m_sq1, m_cq1, m_ov1, m_cnt1;

   initial begin
      int e_s4, e_c4, e_pop4, e_s1, e_c1, e_pop1, lane;

      n_cmp = 0;
      n_err = 0;
      tt[0] = '{a: 1'b0, b: 1'b0, s: 1'b0, c: 1'b0};
      tt[1] = '{a: 1'b0, b: 1'b1, s: 1'b1, c: 1'b0};
      tt[2] = '{a: 1'b1, b: 1'b0, s: 1'b1, c: 1'b0};
      tt[3] = '{a: 1'b1, b: 1'b1, s: 1'b0, c: 1'b1};

      clk_en = 1'b0;
      rst_n  = 1'b0;
      a4 = '0; b4 = '0; iv4 = 1'b0; clr4 = 1'b0;
      a1 = '0; b1 = '0; iv1 = 1'b0; clr1 = 1'b0;

      // 1: truth table, no clock, reset asserted
      for (int i = 0; i < 4; i++) begin
         a1 = tt[i].a;
         b1 = tt[i].b;
         #5;
         chk($sformatf("tt%0d_sum", i), 32'(sum1), 32'(tt[i].s));
         chk($sformatf("tt%0d_carry", i), 32'(carry1), 32'(tt[i].c));
      end
      chk("rst_sq1", 32'(sq1), 32'd0);
      chk("rst_cnt1", 32'(cnt1), 32'd0);
      chk("rst_ov4", 32'(ov4), 32'd0);

      // 2: reset asserted mid-run with a=b=1, in_valid=1
      clk_en = 1'b1;
      #3;
      rst_n = 1'b1;
      a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
      tick();
      tick();
      chk("pre_rst_cq1", 32'(cq1), 32'd1);
      chk("pre_rst_cnt1", 32'(cnt1), 32'd2);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_sq1", 32'(sq1), 32'd0);
      chk("async_rst_cq1", 32'(cq1), 32'd0);
      chk("async_rst_ov1", 32'(ov1), 32'd0);
      chk("async_rst_cnt1", 32'(cnt1), 32'd0);
      chk("async_rst_comb_carry1", 32'(carry1), 32'd1);
      chk("async_rst_comb_sum1", 32'(sum1), 32'd0);
      #1;
      rst_n = 1'b1;
      tick();
      chk("post_rel_cq1", 32'(cq1), 32'd1);
      chk("post_rel_ov1", 32'(ov1), 32'd1);
      chk("post_rel_cnt1", 32'(cnt1), 32'd1);

      // 3: in_valid pulse, hold behaviour
      a1 = 1'b1; b1 = 1'b0; iv1 = 1'b1;
      tick();
      a1 = 1'b1; b1 = 1'b1; iv1 = 1'b0;
      tick();
      chk("hold_sq1", 32'(sq1), 32'd1);
      chk("hold_cq1", 32'(cq1), 32'd0);
      chk("hold_ov1", 32'(ov1), 32'd0);
      chk("hold_cnt1", 32'(cnt1), 32'd1);

      // 4: four lanes, three accepted cycles
      a4 = 4'b1011; b4 = 4'b0111; iv4 = 1'b1;
      #1;
      chk("w4_sum", 32'(sum4), 32'h0000_000c);
      chk("w4_carry", 32'(carry4), 32'h0000_0003);
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk($sformatf("w4_cnt_c%0d", k), 32'(cnt4), 32'(2 * k));
      end
      chk("w4_sq", 32'(sq4), 32'h0000_000c);
      chk("w4_cq", 32'(cq4), 32'h0000_0003);
      chk("w4_ov", 32'(ov4), 32'd1);
      iv4 = 1'b0;

      // 5: saturation of a 3-bit counter, then clear beats increment
      clr1 = 1'b1;
      tick();
      chk("sat_pre_clear", 32'(cnt1), 32'd0);
      clr1 = 1'b0;
      a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk($sformatf("sat_cnt_c%0d", k), 32'(cnt1), 32'((k > 7) ? 7 : k));
      end
      clr1 = 1'b1;
      tick();
      chk("clear_wins", 32'(cnt1), 32'd0);
      clr1 = 1'b0;

      // 6: random stimulus against a lane-arithmetic model
      #1;
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      m_sq4 = 0; m_cq4 = 0; m_ov4 = 0; m_cnt4 = 0;
      m_sq1 = 0; m_cq1 = 0; m_ov1 = 0; m_cnt1 = 0;
      for (int cyc = 0; cyc < 1000; cyc++) begin
         a4   = 4'($urandom);
         b4   = 4'($urandom);
         iv4  = ($urandom_range(3) != 0);
         clr4 = ($urandom_range(15) == 0);
         a1   = 1'($urandom);
         b1   = 1'($urandom);
         iv1  = ($urandom_range(3) != 0);
         clr1 = ($urandom_range(11) == 0);
         #1;

         e_s4 = 0; e_c4 = 0; e_pop4 = 0;
         for (int i = 0; i < 4; i++) begin
            lane   = int'(a4[i]) + int'(b4[i]);
            e_s4   = e_s4 + ((lane % 2) << i);
            e_c4   = e_c4 + ((lane / 2) << i);
            e_pop4 = e_pop4 + lane / 2;
         end
         lane   = int'(a1) + int'(b1);
         e_s1   = lane % 2;
         e_c1   = lane / 2;
         e_pop1 = lane / 2;

         chk("rnd_sum4", 32'(sum4), 32'(e_s4));
         chk("rnd_carry4", 32'(carry4), 32'(e_c4));
         chk("rnd_sum1", 32'(sum1), 32'(e_s1));
         chk("rnd_carry1", 32'(carry1), 32'(e_c1));

         m_ov4 = int'(iv4);
         if (iv4) begin m_sq4 = e_s4; m_cq4 = e_c4; end
         if (clr4) m_cnt4 = 0;
         else if (iv4) m_cnt4 = (m_cnt4 + e_pop4 > 31) ? 31 : m_cnt4 + e_pop4;

         m_ov1 = int'(iv1);
         if (iv1) begin m_sq1 = e_s1; m_cq1 = e_c1; end
         if (clr1) m_cnt1 = 0;
         else if (iv1) m_cnt1 = (m_cnt1 + e_pop1 > 7) ? 7 : m_cnt1 + e_pop1;

         tick();
         chk("rnd_sq4", 32'(sq4), 32'(m_sq4));
         chk("rnd_cq4", 32'(cq4), 32'(m_cq4));
         chk("rnd_ov4", 32'(ov4), 32'(m_ov4));
         chk("rnd_cnt4", 32'(cnt4), 32'(m_cnt4));
         chk("rnd_sq1", 32'(sq1), 32'(m_sq1));
         chk("rnd_cq1", 32'(cq1), 32'(m_cq1));
         chk("rnd_ov1", 32'(ov1), 32'(m_ov1));
         chk("rnd_cnt1", 32'(cnt1), 32'(m_cnt1));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
